// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register with branch/jump resolution, misaligned-target trap FSM and stall hold
module pc_branch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic            alu_zero,
  input  logic            alu_less_than,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            trap_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_target,
  output logic            taken,
  output logic            misaligned,
  output logic [XLEN-1:0] epc
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic ltu, cond, fault;
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    pc_target = jalr ? (rs1_data + imm_ext) & ~XLEN'(1) : pc + imm_ext;
    ltu = rs1_data < rs2_data;
    case (funct3)
      3'b000:  cond = alu_zero;
      3'b001:  cond = ~alu_zero;
      3'b100:  cond = alu_less_than;
      3'b101:  cond = ~alu_less_than;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
    taken = jump | jalr | (branch & cond);
    fault = taken & (pc_target[1:0] != 2'b00);
  end
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    epc_nxt = epc;
    if (state == RUN && !stall) begin
      state_nxt = fault ? TRAP : RUN;
      pc_nxt = fault ? TRAP_VEC : taken ? pc_target : pc_plus4;
      epc_nxt = fault ? pc : epc;
    end else if (state == TRAP && trap_ack) begin
      state_nxt = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_VEC;
      epc <= '0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      epc <= epc_nxt;
    end
  end
  assign misaligned = (state == TRAP);
endmodule
